mips_ctrl_fsm: RTL and testbench

Sequenced control unit that sits directly upstream of the single-cycle MIPS datapath. It consumes the datapath's `OpCode` and drives every datapath control input (RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, Jump, Jal) plus a PC-advance enable. Loads take two cycles to cover the synchronous data memory. Illegal opcodes halt the core.

---
 rtl/mips_ctrl_fsm.sv | 185 ++++++++++++++++++
 tb/tb_mips_ctrl_fsm.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_ctrl_fsm.sv
// mips_ctrl_fsm: sequenced control unit for a single-cycle MIPS datapath.
// It decodes OpCode into the datapath control strobes and a PC-advance
// enable. Loads take a second cycle (LOADWB) so that the synchronous data
// memory can return its data. Illegal opcodes park the core in HALT until
// the next reset.
//
// Optional feature: define MIPS_CTRL_PERF_EN to build the instr_count and
// stall_count performance counters. When it is undefined, both outputs are
// tied to zero and no counter registers exist.

module mips_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       OpCode,
    output logic             RegDst,
    output logic             AluSrc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Branch,
    output logic [1:0]       ALUOp,
    output logic             Jump,
    output logic             Jal,
    output logic             pc_en,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXEC   = 2'd1;
    localparam logic [1:0] S_LOADWB = 2'd2;
    localparam logic [1:0] S_HALT   = 2'd3;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    logic [1:0] state_r;
    logic [1:0] next_state_s;

    // State register; the asynchronous reset also aborts an in-flight
    // LOADWB so no late register write can occur.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Control decode and next-state selection from state and OpCode.
    always_comb begin
        RegDst       = 1'b0;
        AluSrc       = 1'b0;
        MemtoReg     = 1'b0;
        RegWrite     = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        Branch       = 1'b0;
        ALUOp        = ALU_ADD;
        Jump         = 1'b0;
        Jal          = 1'b0;
        pc_en        = 1'b0;
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                // One settle cycle for instruction memory after reset.
                next_state_s = S_EXEC;
            end
            S_EXEC: begin
                next_state_s = S_EXEC;
                case (OpCode)
                    OP_RTYPE: begin
                        RegDst   = 1'b1;
                        RegWrite = 1'b1;
                        ALUOp    = ALU_FUNCT;
                        pc_en    = 1'b1;
                    end
                    OP_ADDI: begin
                        AluSrc   = 1'b1;
                        RegWrite = 1'b1;
                        ALUOp    = ALU_ADD;
                        pc_en    = 1'b1;
                    end
                    OP_LW: begin
                        // Address phase only; the write-back happens in LOADWB.
                        AluSrc       = 1'b1;
                        MemRead      = 1'b1;
                        ALUOp        = ALU_ADD;
                        next_state_s = S_LOADWB;
                    end
                    OP_SW: begin
                        AluSrc   = 1'b1;
                        MemWrite = 1'b1;
                        ALUOp    = ALU_ADD;
                        pc_en    = 1'b1;
                    end
                    OP_BEQ: begin
                        Branch = 1'b1;
                        ALUOp  = ALU_SUB;
                        pc_en  = 1'b1;
                    end
                    OP_J: begin
                        Jump  = 1'b1;
                        pc_en = 1'b1;
                    end
                    OP_JAL: begin
                        Jump     = 1'b1;
                        Jal      = 1'b1;
                        RegWrite = 1'b1;
                        pc_en    = 1'b1;
                    end
                    default: begin
                        // Illegal opcode: no strobes, no retire, halt next edge.
                        next_state_s = S_HALT;
                    end
                endcase
            end
            S_LOADWB: begin
                // OpCode is ignored here: the PC has not moved yet.
                AluSrc       = 1'b1;
                MemRead      = 1'b1;
                MemtoReg     = 1'b1;
                RegWrite     = 1'b1;
                ALUOp        = ALU_ADD;
                pc_en        = 1'b1;
                next_state_s = S_EXEC;
            end
            S_HALT: begin
                next_state_s = S_HALT;
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    assign halted = (state_r == S_HALT);

`ifdef MIPS_CTRL_PERF_EN
    logic [CNT_W-1:0] instr_count_r;
    logic [CNT_W-1:0] stall_count_r;

    // Retired-instruction counter: one count per edge with pc_en high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_count_r <= {CNT_W{1'b0}};
        end else if (pc_en) begin
            instr_count_r <= instr_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            instr_count_r <= instr_count_r;
        end
    end

    // Stall counter: one count per edge taken in LOADWB.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (state_r == S_LOADWB) begin
            stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign instr_count = instr_count_r;
    assign stall_count = stall_count_r;
`else
    assign instr_count = {CNT_W{1'b0}};
    assign stall_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Self-checking bench for mips_ctrl_fsm: directed scenarios followed by
// randomized opcode streams, compared against an instruction-level model
// (settle cycle, pending load, halted flag, retire/stall tallies).

module tb_mips_ctrl_fsm;

    localparam int CNT_W = 32;

    logic             clk;
    logic             reset;
    logic [5:0]       OpCode;
    logic             RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite;
    logic             Branch, Jump, Jal, pc_en, halted;
    logic [1:0]       ALUOp;
    logic [CNT_W-1:0] instr_count, stall_count;

    int checks = 0;
    int errors = 0;

    // Model state
    bit          settle_m;   // first cycle after reset: nothing executes
    bit          pend_m;     // lw address phase done, write-back due
    bit          halt_m;
    int unsigned instr_m;
    int unsigned stall_m;
    int          halt_cycles;

    logic [5:0] legal_ops [7];

    mips_ctrl_fsm #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .OpCode(OpCode),
        .RegDst(RegDst), .AluSrc(AluSrc), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .Branch(Branch), .ALUOp(ALUOp), .Jump(Jump), .Jal(Jal),
        .pc_en(pc_en), .halted(halted),
        .instr_count(instr_count), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        bit r;
        r = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (legal_ops[i] == op) r = 1'b1;
        end
        return r;
    endfunction

    // Expected {RegDst,AluSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp,Jump,Jal,pc_en,halted}
    function automatic logic [12:0] exp_ctrl(input logic [5:0] op);
        logic rd, as, m2r, rw, mr, mw, br, jp, jl, pe, hl;
        logic [1:0] ao;
        {rd, as, m2r, rw, mr, mw, br, jp, jl, pe, hl} = 11'b0;
        ao = 2'b00;
        if (halt_m) begin
            hl = 1'b1;
        end else if (settle_m) begin
            pe = 1'b0;
        end else if (pend_m) begin
            as = 1'b1; mr = 1'b1; m2r = 1'b1; rw = 1'b1; pe = 1'b1;
        end else begin
            case (op)
                6'b000000: begin rd = 1'b1; rw = 1'b1; ao = 2'b10; pe = 1'b1; end
                6'b001000: begin as = 1'b1; rw = 1'b1; pe = 1'b1; end
                6'b100011: begin as = 1'b1; mr = 1'b1; end
                6'b101011: begin as = 1'b1; mw = 1'b1; pe = 1'b1; end
                6'b000100: begin br = 1'b1; ao = 2'b01; pe = 1'b1; end
                6'b000010: begin jp = 1'b1; pe = 1'b1; end
                6'b000011: begin jp = 1'b1; jl = 1'b1; rw = 1'b1; pe = 1'b1; end
                default:   begin pe = 1'b0; end
            endcase
        end
        return {rd, as, m2r, rw, mr, mw, br, ao, jp, jl, pe, hl};
    endfunction

    function automatic logic [12:0] obs_ctrl();
        return {RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch,
                ALUOp, Jump, Jal, pc_en, halted};
    endfunction

    task automatic check_outputs(input string tag);
        logic [CNT_W-1:0] ei, es;
`ifdef MIPS_CTRL_PERF_EN
        ei = instr_m;
        es = stall_m;
`else
        ei = '0;
        es = '0;
`endif
        chk_eq({tag, "_ctrl"}, 64'(obs_ctrl()), 64'(exp_ctrl(OpCode)));
        chk_eq({tag, "_icnt"}, 64'(instr_count), 64'(ei));
        chk_eq({tag, "_scnt"}, 64'(stall_count), 64'(es));
    endtask

    // Called at a negedge: drive op, check, advance the model at posedge.
    task automatic step(input logic [5:0] op, input string tag);
        OpCode = op;
        #1;
        check_outputs(tag);
        @(posedge clk);
        if (halt_m) begin
            halt_cycles++;
        end else if (settle_m) begin
            settle_m = 1'b0;
        end else if (pend_m) begin
            pend_m = 1'b0;
            instr_m++;
            stall_m++;
        end else if (op == 6'b100011) begin
            pend_m = 1'b1;
        end else if (is_legal(op)) begin
            instr_m++;
        end else begin
            halt_m = 1'b1;
            halt_cycles = 0;
        end
        @(negedge clk);
    endtask

    // Assert reset now, check outputs are all zero, hold n cycles, release at a negedge.
    task automatic do_reset(input int n);
        reset = 1'b0;
        settle_m = 1'b1; pend_m = 1'b0; halt_m = 1'b0;
        instr_m = 0; stall_m = 0; halt_cycles = 0;
        #1;
        chk_eq("rst_ctrl", 64'(obs_ctrl()), 64'd0);
        chk_eq("rst_icnt", 64'(instr_count), 64'd0);
        chk_eq("rst_scnt", 64'(stall_count), 64'd0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            chk_eq("rst_hold_ctrl", 64'(obs_ctrl()), 64'd0);
            chk_eq("rst_hold_cnt", 64'(instr_count | stall_count), 64'd0);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [5:0] rand_op(input int illegal_weight);
        logic [5:0] op;
        if ($urandom_range(0, 99) < illegal_weight) begin
            op = 6'($urandom_range(0, 63));
            while (is_legal(op)) op = 6'($urandom_range(0, 63));
        end else begin
            op = legal_ops[$urandom_range(0, 6)];
        end
        return op;
    endfunction

    initial begin
        legal_ops[0] = 6'b000000; legal_ops[1] = 6'b001000; legal_ops[2] = 6'b100011;
        legal_ops[3] = 6'b101011; legal_ops[4] = 6'b000100; legal_ops[5] = 6'b000010;
        legal_ops[6] = 6'b000011;
        OpCode = 6'b000000;

        // Reset and start
        do_reset(3);
        step(6'b000000, "idle");
        // R-type stream
        repeat (4) step(6'b000000, "rtype");
        // lw then sw; OpCode during LOADWB is deliberately junk
        step(6'b100011, "lw_addr");
        step(6'b111111, "lw_wb");
        step(6'b101011, "sw");
        // Branch and jumps
        step(6'b000100, "beq");
        step(6'b000010, "j");
        step(6'b000011, "jal");
        // Illegal opcode then ten cycles of varying OpCode
        step(6'b111111, "illegal");
        for (int i = 0; i < 10; i++) step(6'($urandom_range(0, 63)), "halted");
        do_reset(2);
        step(6'b101011, "idle2");
        // Reset in the middle of a load write-back
        step(6'b100011, "lw_addr2");
        OpCode = 6'b100011;
        #1;
        check_outputs("lw_wb2");
        #2;
        do_reset(2);
        step(6'b000000, "idle3");
        step(6'b000000, "restart_r");
        step(6'b001000, "restart_addi");

        // Randomized streams with occasional illegal opcodes and resets
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) == 0 || (halt_m && halt_cycles > 6)) begin
                do_reset($urandom_range(1, 3));
            end
            step(rand_op(4), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
